eca_engine: RTL and testbench
=============================

// Module: eca_engine
// PURPOSE
//  Parametrised elementary (1-D, radius-1, binary) cellular-automaton engine; next generation of the
//  fixed-rule autocell block. Width, rule and boundary mode are configurable; runs for a counted
//  number of generations under a start/stop/done handshake and flags fixed points. Sits between
//  the host/testbench control and the display or capture logic that reads the cell array.
// PARAMETERS
//  WIDTH   20  number of cells (>=3)
//  CNT_W   16  width of step count and generation counter
// PORTS
//  clk       in   1        clock, all state updates on rising edge
//  res       in   1        asynchronous reset, active-low
//  load      in   1        copy init into state, clear gen (accepted in IDLE/DONE only)
//  init      in   WIDTH    initial cell pattern
//  rule      in   8        Wolfram rule number; sampled at start
//  bmode     in   2        boundary: 00 periodic, 01 fixed 0, 10 fixed 1, 11 reflect; sampled at start
//  nsteps    in   CNT_W    generations to compute; sampled at start
//  halt_fix  in   1        end run early when a step leaves state unchanged; sampled at start
//  start     in   1        begin run (accepted in IDLE/DONE, load low)
//  stop      in   1        abort run, return to IDLE
//  state     out  WIDTH    current cell array
//  gen       out  CNT_W    generations computed since last load (wraps modulo 2^CNT_W)
//  busy      out  1        high in RUN
//  done      out  1        high in DONE until next load/start
//  stable    out  1        last computed step produced next==state
// BEHAVIOUR
//  - Reset (async, res=0): state=0, gen=0, busy=0, done=0, stable=0, FSM=IDLE, latched cfg=0.
//  - Neighbourhood of cell i = {left=state[i+1], centre=state[i], right=state[i-1]}; next[i]=rule[nbhd].
//  - Boundary cells: periodic -> index wraps (i=0 right nbr = state[WIDTH-1]; i=WIDTH-1 left = state[0]);
//    fixed 0/1 -> missing neighbour is constant; reflect -> missing neighbour = the edge cell itself.
//  - FSM IDLE/DONE: load=1 -> state<=init, gen<=0, stable<=0, done<=0, stay/go IDLE.
//    load=0 & start=1 -> latch rule/bmode/nsteps/halt_fix, remaining<=nsteps, done<=0;
//      nsteps==0 -> DONE next cycle, no update; else -> RUN.  load has priority over start.
//  - RUN: one generation per cycle: state<=next, gen<=gen+1, remaining<=remaining-1,
//    stable<=(next==state). Go DONE after the step where remaining hits 0, or (halt_fix & next==state).
//    stop=1 in RUN -> IDLE next edge, no step that cycle, state/gen held, done stays 0.
//    load and start ignored in RUN. stop outside RUN ignored.
//  - First step on the edge after start accepted; N steps -> busy high exactly N cycles, done
//    rises on the edge that commits step N.
//  - Changes on rule/bmode/nsteps/halt_fix during RUN have no effect (latched copies used).
//  - Reset asserted mid-run aborts immediately to reset values.
// STRUCTURE
//  - eca_pkg: bmode constants (BM_PERIODIC, BM_ZERO, BM_ONE, BM_REFLECT), FSM state typedef
//    (S_IDLE, S_RUN, S_DONE).
//  - Sub-module eca_next #(WIDTH): purely combinational rule/bmode/state -> next, generate loop over
//    cells; eca_engine holds FSM, counters, config latches and the state register.
// TESTING
//  1 WIDTH=20, rule 184, periodic, init 0x00001, nsteps=1 -> state 0x80000, gen=1, done=1, busy 1 cycle.
//  2 rule 90, periodic, init 0x00400, nsteps=1 -> state 0x00A00; nsteps=0 -> done next cycle, state unchanged.
//  3 rule 184, fixed 0, init 0x00001, nsteps=1 -> state 0x00000; fixed 1 same init -> bit19 from boundary
//    checked against reference model for all four bmodes over 50 random inits.
//  4 rule 204, halt_fix=1, nsteps=10 -> done after 1 step, gen=1, stable=1; halt_fix=0 -> gen=10.
//  5 rule 30, nsteps=100, stop at gen=5 -> IDLE next edge, gen=5, done=0; start/load during RUN ignored.
//  6 res pulsed low mid-run -> all outputs 0 immediately; CNT_W=4, 20 steps -> gen wraps to 4.

Source files
------------

// File: rtl/eca_pkg.sv
// Shared constants and types for the elementary cellular-automaton engine.
package eca_pkg;

  localparam logic [1:0] BM_PERIODIC = 2'b00;
  localparam logic [1:0] BM_ZERO     = 2'b01;
  localparam logic [1:0] BM_ONE      = 2'b10;
  localparam logic [1:0] BM_REFLECT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } fsm_e;

endpackage

// File: rtl/eca_if.sv
// Control/status bundle between the host and the CA engine.
interface eca_if #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned CNT_W = 16
);

  logic             load;
  logic [WIDTH-1:0] init;
  logic [7:0]       rule;
  logic [1:0]       bmode;
  logic [CNT_W-1:0] nsteps;
  logic             halt_fix;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] state;
  logic [CNT_W-1:0] gen;
  logic             busy;
  logic             done;
  logic             stable;

  modport master (
    output load, init, rule, bmode, nsteps, halt_fix, start, stop,
    input  state, gen, busy, done, stable
  );

  modport slave (
    input  load, init, rule, bmode, nsteps, halt_fix, start, stop,
    output state, gen, busy, done, stable
  );

endinterface

// File: rtl/eca_next.sv
// Combinational next-generation function: applies an 8-bit Wolfram rule to every cell
// with a selectable boundary treatment at the two edge cells.
module eca_next
  import eca_pkg::*;
#(
  parameter int unsigned WIDTH = 20
) (
  input  logic [7:0]       rule,
  input  logic [1:0]       bmode,
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  // Virtual neighbours beyond the MSB (left) and LSB (right) edges.
  logic lb;
  logic rb;

  always_comb begin
    lb = 1'b0;
    rb = 1'b0;
    case (bmode)
      BM_PERIODIC: begin
        lb = cur[0];
        rb = cur[WIDTH-1];
      end
      BM_ZERO: begin
        lb = 1'b0;
        rb = 1'b0;
      end
      BM_ONE: begin
        lb = 1'b1;
        rb = 1'b1;
      end
      BM_REFLECT: begin
        lb = cur[WIDTH-1];
        rb = cur[0];
      end
      default: begin
        lb = 1'b0;
        rb = 1'b0;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic l;
    logic r;
    if (i == WIDTH - 1) begin : g_left_edge
      assign l = lb;
    end else begin : g_left_inner
      assign l = cur[i+1];
    end
    if (i == 0) begin : g_right_edge
      assign r = rb;
    end else begin : g_right_inner
      assign r = cur[i-1];
    end
    assign nxt[i] = rule[{l, cur[i], r}];
  end

endmodule

// File: rtl/eca_engine.sv
// Elementary CA engine: runs a counted number of generations under start/stop/done
// control, with latched configuration and fixed-point detection.
module eca_engine
  import eca_pkg::*;
#(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned CNT_W = 16
) (
  input logic clk,
  input logic res,
  eca_if.slave bus
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  fsm_e             st_q, st_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0] gen_q, gen_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             stable_q, stable_d;
  logic [7:0]       rule_q, rule_d;
  logic [1:0]       bmode_q, bmode_d;
  logic             halt_q, halt_d;

  logic [WIDTH-1:0] next_state;
  logic             same;

  eca_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .rule (rule_q),
    .bmode(bmode_q),
    .cur  (state_q),
    .nxt  (next_state)
  );

  assign same = (next_state == state_q);

  always_comb begin
    st_d     = st_q;
    state_d  = state_q;
    gen_d    = gen_q;
    rem_d    = rem_q;
    stable_d = stable_q;
    rule_d   = rule_q;
    bmode_d  = bmode_q;
    halt_d   = halt_q;
    case (st_q)
      S_IDLE, S_DONE: begin
        if (bus.load) begin
          state_d  = bus.init;
          gen_d    = '0;
          stable_d = 1'b0;
          st_d     = S_IDLE;
        end else if (bus.start) begin
          rule_d  = bus.rule;
          bmode_d = bus.bmode;
          halt_d  = bus.halt_fix;
          rem_d   = bus.nsteps;
          st_d    = (bus.nsteps == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          st_d = S_IDLE;
        end else begin
          state_d  = next_state;
          gen_d    = gen_q + CntOne;
          rem_d    = rem_q - CntOne;
          stable_d = same;
          // rem_q==1 means this edge commits the final requested step.
          if ((rem_q == CntOne) || (halt_q && same)) begin
            st_d = S_DONE;
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      st_q     <= S_IDLE;
      state_q  <= '0;
      gen_q    <= '0;
      rem_q    <= '0;
      stable_q <= 1'b0;
      rule_q   <= '0;
      bmode_q  <= '0;
      halt_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      state_q  <= state_d;
      gen_q    <= gen_d;
      rem_q    <= rem_d;
      stable_q <= stable_d;
      rule_q   <= rule_d;
      bmode_q  <= bmode_d;
      halt_q   <= halt_d;
    end
  end

  assign bus.state  = state_q;
  assign bus.gen    = gen_q;
  assign bus.busy   = (st_q == S_RUN);
  assign bus.done   = (st_q == S_DONE);
  assign bus.stable = stable_q;

endmodule

// File: tb/tb_eca_engine.sv
// Directed bench for eca_engine: WIDTH=20 with CNT_W=16 and a CNT_W=4 instance for wrap.
module tb_eca_engine;

  logic clk;
  logic res;
  int   total;
  int   bad;

  eca_if #(.WIDTH(20), .CNT_W(16)) bus ();
  eca_if #(.WIDTH(20), .CNT_W(4))  bus4 ();

  eca_engine #(.WIDTH(20), .CNT_W(16)) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  eca_engine #(.WIDTH(20), .CNT_W(4)) dut4 (
    .clk(clk),
    .res(res),
    .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference for one generation.
  function automatic logic [19:0] ref_step(input logic [19:0] s, input logic [7:0] r,
                                           input logic [1:0] bm);
    logic [19:0] n;
    logic        l;
    logic        rt;
    n = '0;
    for (int i = 0; i < 20; i++) begin
      if (i == 19) begin
        case (bm)
          2'd0: l = s[0];
          2'd1: l = 1'b0;
          2'd2: l = 1'b1;
          default: l = s[19];
        endcase
      end else begin
        l = s[i+1];
      end
      if (i == 0) begin
        case (bm)
          2'd0: rt = s[19];
          2'd1: rt = 1'b0;
          2'd2: rt = 1'b1;
          default: rt = s[0];
        endcase
      end else begin
        rt = s[i-1];
      end
      n[i] = r[{l, s[i], rt}];
    end
    return n;
  endfunction

  task automatic do_load(input logic [19:0] v);
    bus.init = v;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] r, input logic [1:0] bm, input logic [15:0] n,
                          input logic h);
    bus.rule     = r;
    bus.bmode    = bm;
    bus.nsteps   = n;
    bus.halt_fix = h;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts cycles with busy high; bounded so a stuck DUT cannot hang the run.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy && cyc < 500) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    res = 1'b0;
    bus.load = 0; bus.init = '0; bus.rule = '0; bus.bmode = '0; bus.nsteps = '0;
    bus.halt_fix = 0; bus.start = 0; bus.stop = 0;
    bus4.load = 0; bus4.init = '0; bus4.rule = '0; bus4.bmode = '0; bus4.nsteps = '0;
    bus4.halt_fix = 0; bus4.start = 0; bus4.stop = 0;
    #7;
    total++;
    if ({bus.state, bus.gen, bus.busy, bus.done, bus.stable} !== 39'd0) begin
      bad++;
      $display("FAIL reset: got state=%h gen=%0d busy=%b done=%b stable=%b want all 0",
               bus.state, bus.gen, bus.busy, bus.done, bus.stable);
    end
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rule184;
    int cyc;
    do_load(20'h00001);
    do_start(8'd184, 2'b00, 16'd1, 1'b0);
    wait_idle(cyc);
    total++;
    if (cyc !== 1) begin
      bad++; $display("FAIL r184_busy: got %0d want 1", cyc);
    end
    total++;
    if (bus.state !== 20'h80000) begin
      bad++; $display("FAIL r184_state: got %h want 80000", bus.state);
    end
    total++;
    if (bus.gen !== 16'd1 || bus.done !== 1'b1) begin
      bad++; $display("FAIL r184_gen_done: got gen=%0d done=%b want 1 1", bus.gen, bus.done);
    end
  endtask

  task automatic test_rule90;
    int cyc;
    do_load(20'h00400);
    do_start(8'd90, 2'b00, 16'd1, 1'b0);
    wait_idle(cyc);
    total++;
    if (bus.state !== 20'h00A00) begin
      bad++; $display("FAIL r90_state: got %h want 00a00", bus.state);
    end
    do_start(8'd90, 2'b00, 16'd0, 1'b0);
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.state !== 20'h00A00 || bus.gen !== 16'd1)
    begin
      bad++;
      $display("FAIL zero_steps: got done=%b busy=%b state=%h gen=%0d want 1 0 00a00 1",
               bus.done, bus.busy, bus.state, bus.gen);
    end
  endtask

  task automatic test_boundary;
    int          cyc;
    logic [19:0] exp_s [3];
    logic [19:0] iv;
    logic [7:0]  r;
    exp_s[0] = 20'h00000;
    exp_s[1] = 20'h80001;
    exp_s[2] = 20'h00001;
    for (int b = 1; b < 4; b++) begin
      do_load(20'h00001);
      do_start(8'd184, 2'(b), 16'd1, 1'b0);
      wait_idle(cyc);
      total++;
      if (bus.state !== exp_s[b-1]) begin
        bad++; $display("FAIL bound_bm%0d: got %h want %h", b, bus.state, exp_s[b-1]);
      end
    end
    for (int k = 0; k < 50; k++) begin
      iv = 20'($urandom);
      r  = 8'($urandom);
      do_load(iv);
      do_start(r, 2'(k % 4), 16'd1, 1'b0);
      wait_idle(cyc);
      total++;
      if (bus.state !== ref_step(iv, r, 2'(k % 4))) begin
        bad++;
        $display("FAIL rand_step%0d: got %h want %h (init=%h rule=%0d bm=%0d)", k, bus.state,
                 ref_step(iv, r, 2'(k % 4)), iv, r, k % 4);
      end
    end
  endtask

  task automatic test_halt_fix;
    int cyc;
    do_load(20'h5A5A5);
    do_start(8'd204, 2'b00, 16'd10, 1'b1);
    wait_idle(cyc);
    total++;
    if (cyc !== 1 || bus.gen !== 16'd1 || bus.stable !== 1'b1 || bus.done !== 1'b1) begin
      bad++;
      $display("FAIL halt_on: got cyc=%0d gen=%0d stable=%b done=%b want 1 1 1 1",
               cyc, bus.gen, bus.stable, bus.done);
    end
    do_load(20'h5A5A5);
    total++;
    if (bus.stable !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL load_clear: got stable=%b done=%b want 0 0", bus.stable, bus.done);
    end
    do_start(8'd204, 2'b00, 16'd10, 1'b0);
    wait_idle(cyc);
    total++;
    if (cyc !== 10 || bus.gen !== 16'd10 || bus.stable !== 1'b1 || bus.state !== 20'h5A5A5) begin
      bad++;
      $display("FAIL halt_off: got cyc=%0d gen=%0d stable=%b state=%h want 10 10 1 5a5a5",
               cyc, bus.gen, bus.stable, bus.state);
    end
  endtask

  task automatic test_stop;
    logic [19:0] m;
    do_load(20'h00400);
    do_start(8'd30, 2'b00, 16'd100, 1'b0);
    // load/start/config changes during RUN must be ignored
    bus.load = 1'b1; bus.init = 20'hFFFFF; bus.start = 1'b1; bus.rule = 8'd0;
    @(negedge clk);
    bus.load = 1'b0; bus.start = 1'b0;
    total++;
    if (bus.gen !== 16'd1 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL run_ignore: got gen=%0d busy=%b want 1 1", bus.gen, bus.busy);
    end
    repeat (4) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    m = 20'h00400;
    for (int i = 0; i < 5; i++) m = ref_step(m, 8'd30, 2'b00);
    total++;
    if (bus.gen !== 16'd5 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL stop: got gen=%0d busy=%b done=%b want 5 0 0", bus.gen, bus.busy, bus.done);
    end
    total++;
    if (bus.state !== m) begin
      bad++; $display("FAIL stop_state: got %h want %h", bus.state, m);
    end
    @(negedge clk);
    total++;
    if (bus.gen !== 16'd5) begin
      bad++; $display("FAIL idle_hold: got gen=%0d want 5", bus.gen);
    end
  endtask

  task automatic test_reset_midrun;
    do_load(20'h00400);
    do_start(8'd30, 2'b00, 16'd100, 1'b0);
    repeat (3) @(negedge clk);
    #2 res = 1'b0;
    #1;
    total++;
    if ({bus.state, bus.gen, bus.busy, bus.done, bus.stable} !== 39'd0) begin
      bad++;
      $display("FAIL midrun_reset: got state=%h gen=%0d busy=%b done=%b stable=%b want all 0",
               bus.state, bus.gen, bus.busy, bus.done, bus.stable);
    end
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_gen_wrap;
    int cyc;
    bus4.init = 20'h00400;
    bus4.load = 1'b1;
    @(negedge clk);
    bus4.load = 1'b0;
    for (int run = 0; run < 2; run++) begin
      bus4.rule   = 8'd30;
      bus4.nsteps = (run == 0) ? 4'd15 : 4'd5;
      bus4.start  = 1'b1;
      @(negedge clk);
      bus4.start = 1'b0;
      cyc = 0;
      while (bus4.busy && cyc < 100) begin
        cyc++;
        @(negedge clk);
      end
    end
    total++;
    if (bus4.gen !== 4'd4 || bus4.done !== 1'b1) begin
      bad++; $display("FAIL gen_wrap: got gen=%0d done=%b want 4 1", bus4.gen, bus4.done);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_rule184();
    test_rule90();
    test_boundary();
    test_halt_fix();
    test_stop();
    test_reset_midrun();
    test_gen_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
